// File: rtl/vga_timing.sv
// VGA raster generator: pixel/line counters with registered row, col, sync and blank outputs.
// Optional frame counter output enabled by defining VGA_FRAME_COUNT_EN.
module vga_timing #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter int SYNC_POS  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pix_en,
  output logic [9:0]  row,
  output logic [9:0]  col,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 2047 || V_TOTAL > 1023) begin : g_bad_timing
    $error("vga_timing: H_TOTAL must be <= 2047 and V_TOTAL <= 1023");
  end

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEGIN   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0]  VS_BEGIN   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        SYNC_ON    = (SYNC_POS != 0);

  logic [10:0] hcount, h_next;
  logic [9:0]  vcount, v_next;
  logic        h_wrap, frame_wrap;
  logic        blank_next, hs_next, vs_next;

  // Outputs are decoded from the next-state counters so they line up with the
  // counter values they describe, with no extra pipeline stage.
  always_comb begin
    h_wrap     = (hcount == H_LAST);
    frame_wrap = h_wrap && (vcount == V_LAST);
    h_next     = h_wrap ? 11'd0 : hcount + 11'd1;
    if (frame_wrap)  v_next = 10'd0;
    else if (h_wrap) v_next = vcount + 10'd1;
    else             v_next = vcount;
    blank_next = !((h_next < H_VIS_END) && (v_next < V_VIS_END));
    hs_next    = (h_next >= HS_BEGIN) && (h_next < HS_END);
    vs_next    = (v_next >= VS_BEGIN) && (v_next < VS_END);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      hcount      <= 11'd0;
      vcount      <= 10'd0;
      row         <= 10'd0;
      col         <= 10'd0;
      blank       <= 1'b0;
      hsync       <= !SYNC_ON;
      vsync       <= !SYNC_ON;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else if (pix_en) begin
      hcount      <= h_next;
      vcount      <= v_next;
      col         <= blank_next ? 10'd0 : h_next[9:0];
      row         <= blank_next ? 10'd0 : v_next;
      blank       <= blank_next;
      hsync       <= hs_next ? SYNC_ON : !SYNC_ON;
      vsync       <= vs_next ? SYNC_ON : !SYNC_ON;
      line_start  <= (h_next == 11'd0);
      frame_start <= (h_next == 11'd0) && (v_next == 10'd0);
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset)                   frame_cnt <= 16'd0;
    else if (pix_en && frame_wrap) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: per-cycle comparison against a tick-position model,
// plus directed literal checks. Vertical timing is shortened so whole frames fit in the run.
module tb_vga_timing;

  localparam int H_VIS = 800, H_FP = 40, H_SY = 128, H_BP = 88;
  localparam int V_VIS = 6,   V_FP = 1,  V_SY = 2,   V_BP = 2;
  localparam int SYNC  = 1;
  localparam int H_TOT = H_VIS + H_FP + H_SY + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SY + V_BP;
  localparam int FRAME = H_TOT * V_TOT;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pix_en = 1'b0;
  logic [9:0] row, col;
  logic       hsync, vsync, blank, line_start, frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_timing #(
    .H_VISIBLE(H_VIS), .H_FRONT(H_FP), .H_SYNC(H_SY), .H_BACK(H_BP),
    .V_VISIBLE(V_VIS), .V_FRONT(V_FP), .V_SYNC(V_SY), .V_BACK(V_BP),
    .SYNC_POS(SYNC)
  ) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en),
    .row(row), .col(col), .hsync(hsync), .vsync(vsync), .blank(blank),
    .line_start(line_start), .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: position is simply the number of pixel ticks since the start of the frame.
  int          pos = 0;
  logic [15:0] exp_frames = 16'd0;
  bit          model_valid = 1'b0;

  always @(posedge clock) begin
    if (!reset) begin
      pos         <= 0;
      exp_frames  <= 16'd0;
      model_valid <= 1'b1;
    end else if (pix_en) begin
      pos <= (pos + 1) % FRAME;
      if (pos == FRAME - 1) exp_frames <= exp_frames + 16'd1;
    end
  end

  function automatic logic [24:0] expected(input int p);
    int h, v;
    bit vis, hs, vs;
    logic [9:0] er, ec;
    h   = p % H_TOT;
    v   = p / H_TOT;
    vis = (h < H_VIS) && (v < V_VIS);
    hs  = ((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SY)) ^ (SYNC == 0);
    vs  = ((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SY)) ^ (SYNC == 0);
    er  = vis ? 10'(v) : 10'd0;
    ec  = vis ? 10'(h) : 10'd0;
    return {er, ec, hs, vs, !vis, h == 0, p == 0};
  endfunction

  always @(negedge clock) begin
    if (model_valid) begin
      check("raster", 32'({row, col, hsync, vsync, blank, line_start, frame_start}),
            32'(expected(pos)));
`ifdef VGA_FRAME_COUNT_EN
      check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    int t, hs_cnt, hs_first, vs_cnt, vs_first, fs_cnt;

    step(2);
    reset = 1'b1;
    check("reset_state", 32'({row, col, hsync, vsync, blank, line_start, frame_start}),
          32'({10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}));

    pix_en = 1'b1;
    step(799);
    check("col_799", 32'(col), 32'd799);
    check("blank_799", 32'(blank), 32'd0);
    step(1);
    check("col_800", 32'(col), 32'd0);
    check("blank_800", 32'(blank), 32'd1);

    hs_cnt = 0; hs_first = -1;
    for (t = 801; t <= H_TOT; t++) begin
      step(1);
      if (hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = t;
      end
    end
    check("hsync_width", 32'(hs_cnt), 32'd128);
    check("hsync_start", 32'(hs_first), 32'd840);
    check("line1_row", 32'(row), 32'd1);
    check("line1_ls_fs", 32'({line_start, frame_start}), 32'b10);

    vs_cnt = 0; vs_first = -1; fs_cnt = 0;
    for (int i = 1; i <= FRAME; i++) begin
      step(1);
      t++;
      if (vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = t - 1;
      end
      if (frame_start) fs_cnt++;
    end
    check("vsync_ticks", 32'(vs_cnt), 32'd2112);
    check("vsync_start", 32'(vs_first), 32'd7392);
    check("frame_pulses", 32'(fs_cnt), 32'd1);
    check("frame_end_pos", 32'({row, col}), 32'({10'd1, 10'd0}));

    reset = 1'b0; pix_en = 1'b0;
    step(1);
    reset = 1'b1;
    for (int c = 0; c < 2 * H_TOT; c++) begin
      pix_en = (c % 2 == 0);
      step(1);
    end
    pix_en = 1'b0;
    check("alt_line", 32'({row, col, line_start}), 32'({10'd1, 10'd0, 1'b1}));

    reset = 1'b0;
    step(1);
    reset = 1'b1; pix_en = 1'b1;
    step(3 * H_TOT + 400);
    pix_en = 1'b0;
    check("mid_pos", 32'({row, col}), 32'({10'd3, 10'd400}));
    step(2);
    check("mid_hold", 32'({row, col}), 32'({10'd3, 10'd400}));
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    check("mid_reset", 32'({row, col, hsync, vsync, frame_start}),
          32'({10'd0, 10'd0, 1'b0, 1'b0, 1'b1}));
    pix_en = 1'b1;
    step(1);
    check("first_tick", 32'({row, col}), 32'({10'd0, 10'd1}));
    pix_en = 1'b0;

`ifdef VGA_FRAME_COUNT_EN
    reset = 1'b0;
    step(1);
    reset = 1'b1; pix_en = 1'b1;
    step(3 * FRAME);
    pix_en = 1'b0;
    check("three_frames", 32'(frame_cnt), 32'd3);
`endif

    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Generates the VGA raster that the pixel renderers (border, players, trails) consume: row/col pixel coordinates, hsync, vsync and blank.
- Default mode is 800x600 @ 60 Hz with a 40 MHz pixel rate, which matches the 800x600 coordinate space the renderers assume.
- Sits between the clock/reset domain and the renderer and RGB output stage. Downstream logic forces RGB to black whenever blank=1.

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BACK, 88, horizontal back porch (pixels)
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines)
- SYNC_POS, 1, 1 = sync pulses active-high, 0 = active-low

Ports:
- clock  input  1  pixel-domain clock
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clock edge)
- pix_en  input  1  pixel-tick enable; counters advance only on cycles with pix_en=1
- row  output  10  current visible line, 0..V_VISIBLE-1; 0 outside visible area
- col  output  10  current visible pixel, 0..H_VISIBLE-1; 0 outside visible area
- hsync  output  1  horizontal sync, polarity per SYNC_POS
- vsync  output  1  vertical sync, polarity per SYNC_POS
- blank  output  1  1 whenever the position is outside the visible area
- line_start  output  1  one-pixel pulse at hcount==0
- frame_start  output  1  one-pixel pulse at hcount==0 && vcount==0

Behaviour:
- Internal counters: hcount (11 b), 0..H_TOTAL-1, with H_TOTAL = sum of the H_* parameters (1056). vcount (10 b), 0..V_TOTAL-1, with V_TOTAL = sum of the V_* parameters (628).
- On a cycle with pix_en=1:
  - if hcount==H_TOTAL-1, hcount wraps to 0 and vcount increments;
  - otherwise hcount increments.
- vcount wraps to 0 when hcount==H_TOTAL-1 and vcount==V_TOTAL-1 (simultaneous wrap of both counters).
- pix_en=0: all counters and outputs hold their values.
- All outputs are registered and decoded from the next-state counter values. Outputs therefore correspond exactly to the current hcount/vcount with no extra latency; there is no skew between row/col and sync/blank.
- Visible region: hvis = hcount<H_VISIBLE; vvis = vcount<V_VISIBLE. blank = !(hvis && vvis).
- hsync asserted (per SYNC_POS) for H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 840..967 by default.
- vsync asserted for V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC, i.e. 601..604 by default, for whole lines.
- col = hcount[9:0] when hvis, else 0. row = vcount when vvis, else 0. Both are forced to 0 when blank, even in the partially visible cases.
- Reset (reset==0 at a clock edge, regardless of pix_en):
  - hcount=0, vcount=0;
  - row=0, col=0, blank=0;
  - hsync, vsync deasserted (level !SYNC_POS);
  - line_start=1, frame_start=1 (position 0,0).
- Reset mid-frame immediately returns to (0,0); there is no partial-frame completion.
- The first pix_en after reset release advances to hcount=1.
- Widths: H_TOTAL must be <= 2047 and V_TOTAL <= 1023; an elaboration-time error is required otherwise.

Optional Feature:
- Macro VGA_FRAME_COUNT_EN.
- Defined:
  - adds output frame_cnt (16 b), reset to 0;
  - frame_cnt increments by 1 on each pix_en cycle in which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0);
  - wraps 16'hFFFF -> 0.
  - Used by game logic as a tick source.
- Not defined: the port and its logic are absent and all other behaviour is identical.

Test Plan:
- Reset then pix_en=1 continuously:
  - first cycle: row=0, col=0, blank=0, frame_start=1;
  - after 799 ticks: col=799, blank=0;
  - tick 800: col=0, blank=1.
- Run one full line: hsync asserted exactly at hcount 840..967 (128 ticks). After 1056 ticks: hcount=0, row=1, line_start=1, frame_start=0.
- Run a full frame (1056*628 = 663168 ticks):
  - vsync asserted on lines 601..604 only;
  - frame_start pulses once per 663168 ticks;
  - row never exceeds 599 while blank=0.
- pix_en toggled 1/0 alternately: outputs change only on pix_en=1 cycles; one line takes 2112 clocks.
- Assert reset=0 for one cycle at row=300, col=400 with pix_en=0: next cycle row=0, col=0, hsync/vsync deasserted, frame_start=1.
- VGA_FRAME_COUNT_EN defined: after 3 full frames frame_cnt=3. Preloading the counter to 16'hFFFF (force) and completing one frame gives frame_cnt=0.
